// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and types for the 7-segment scan driver.
//   DIGITS    - number of multiplexed digits on the display bus
//   HEX_SEG7  - nibble -> segment pattern, active-high, bits [6:0] = g..a
//   phase_t   - what the current slot cycle is doing (dark, gap, lit)
package seg7_pkg;

  localparam int unsigned DIGITS = 4;

  localparam logic [6:0] HEX_SEG7 [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    PH_OFF,
    PH_BLANK,
    PH_SHOW
  } phase_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundle between the note-code lookup stage and the
// display scan driver.
//   EN          - scan enable; low forces the display dark
//   DISPLAY_NUM - four hex nibbles, [3:0] is digit 0 (rightmost)
//   DP_MASK     - decimal-point request per digit
//   SEG         - segment drive, [6:0] = g..a, [7] = dp
//   DIG         - one-hot digit enable, DIG[i] drives digit i
//   FRAME_STB   - one-cycle pulse when a new frame snapshot is latched
// master = producer/observer side, slave = scan driver.
interface seg7_scan_driver_if;
  logic        EN;
  logic [15:0] DISPLAY_NUM;
  logic [3:0]  DP_MASK;
  logic [7:0]  SEG;
  logic [3:0]  DIG;
  logic        FRAME_STB;

  modport master (
    output EN, DISPLAY_NUM, DP_MASK,
    input  SEG, DIG, FRAME_STB
  );

  modport slave (
    input  EN, DISPLAY_NUM, DP_MASK,
    output SEG, DIG, FRAME_STB
  );
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex_to_seg7: combinational nibble -> 7-segment decoder.
//   nib - hex digit 0..F
//   seg - active-high segments, [6:0] = g..a
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX_SEG7[nib];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexes four hex nibbles onto a common-bus
// 4-digit 7-segment display with a blanking gap at the start of each digit
// slot. DISPLAY_NUM/DP_MASK are snapshotted once per frame (last cycle of
// digit 3), so a frame never mixes two input values.
// Ports:
//   CLK - system clock
//   RST - asynchronous reset, active-high
//   bus - seg7_scan_driver_if.slave (EN, DISPLAY_NUM, DP_MASK in;
//         SEG, DIG, FRAME_STB out, all outputs registered)
// Optional build macro SEG7_LZ_BLANK_EN: leading-zero suppression on
// digits 3..1 (segments dark, digit enable still cycles).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int BLANK_CYCLES   = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic             CLK,
  input  logic             RST,
  seg7_scan_driver_if.slave bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]   BLANK_LIM = (CW + 1)'(BLANK_CYCLES);
  localparam logic [1:0]    IDX_MAX   = 2'(DIGITS - 1);
  localparam logic [7:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [3:0]    DIG_OFF   = (DIG_ACTIVE_LOW != 0) ? 4'hF : 4'h0;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow_num;
  logic [3:0]    shadow_dp;
  logic [7:0]    seg_q;
  logic [3:0]    dig_q;
  logic          stb_q;

  phase_t        phase;
  logic [3:0]    nib;
  logic [6:0]    seg_dec;
  logic          lz_dark;
  logic [7:0]    seg_hi;
  logic [7:0]    seg_show;
  logic [3:0]    dig_show;

  always_comb begin
    nib = shadow_num[{idx, 2'b00} +: 4];
  end

  hex_to_seg7 u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_comb begin
    if (!bus.EN) begin
      phase = PH_OFF;
    end else if ({1'b0, cnt} < BLANK_LIM) begin
      phase = PH_BLANK;
    end else begin
      phase = PH_SHOW;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero only if it and every more significant digit
  // are zero; its own DP request keeps it lit. Digit 0 is never suppressed.
  always_comb begin
    lz_dark = 1'b0;
    case (idx)
      2'd3: lz_dark = (shadow_num[15:12] == 4'h0) && !shadow_dp[3];
      2'd2: lz_dark = (shadow_num[15:8]  == 8'h00) && !shadow_dp[2];
      2'd1: lz_dark = (shadow_num[15:4]  == 12'h000) && !shadow_dp[1];
      default: lz_dark = 1'b0;
    endcase
  end
`else
  always_comb begin
    lz_dark = 1'b0;
  end
`endif

  always_comb begin
    seg_hi = {shadow_dp[idx], seg_dec};
    if (lz_dark) begin
      seg_hi = '0;
    end
    seg_show = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    dig_show = (DIG_ACTIVE_LOW != 0) ? ~(4'b0001 << idx) : (4'b0001 << idx);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt        <= '0;
      idx        <= '0;
      shadow_num <= '0;
      shadow_dp  <= '0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
      stb_q      <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (phase == PH_OFF) begin
        cnt   <= '0;
        idx   <= '0;
        seg_q <= SEG_OFF;
        dig_q <= DIG_OFF;
      end else begin
        if (cnt == CNT_MAX) begin
          cnt <= '0;
          idx <= (idx == IDX_MAX) ? 2'd0 : idx + 2'd1;
          if (idx == IDX_MAX) begin
            shadow_num <= bus.DISPLAY_NUM;
            shadow_dp  <= bus.DP_MASK;
            stb_q      <= 1'b1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (phase == PH_BLANK) begin
          seg_q <= SEG_OFF;
          dig_q <= DIG_OFF;
        end else begin
          seg_q <= seg_show;
          dig_q <= dig_show;
        end
      end
    end
  end

  assign bus.SEG       = seg_q;
  assign bus.DIG       = dig_q;
  assign bus.FRAME_STB = stb_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed bench for seg7_scan_driver with
// SCAN_DIV = 8, BLANK_CYCLES = 2, active-low segments and digits.
// Expected values are hand-computed; lines are sampled 1 time unit after
// the rising edge. Honors SEG7_LZ_BLANK_EN for the leading-zero cases.
module tb_seg7_scan_driver;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .SCAN_DIV       (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] seg, input logic [3:0] dig);
    chk({tag, "_seg"}, bus.SEG, seg);
    chk({tag, "_dig"}, {4'h0, bus.DIG}, {4'h0, dig});
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    RST             = 1'b1;
    bus.EN          = 1'b0;
    bus.DISPLAY_NUM = 16'h0000;
    bus.DP_MASK     = 4'b0000;
    #1;
    chk_out("reset", 8'hFF, 4'hF);
    chk("reset_stb", {7'd0, bus.FRAME_STB}, 8'h00);
    tick(2);

    // Test 1: scan 1234; frame 0 still shows the reset shadow (0000)
    RST             = 1'b0;
    bus.EN          = 1'b1;
    bus.DISPLAY_NUM = 16'h1234;
    tick(1);                                   // edge 0
    chk_out("f0_blank", 8'hFF, 4'hF);
    tick(2);                                   // edge 2
    chk_out("f0_d0_zero", 8'hC0, 4'hE);
    tick(28);                                  // edge 30
    chk("stb_early", {7'd0, bus.FRAME_STB}, 8'h00);
    tick(1);                                   // edge 31
    chk("stb_31", {7'd0, bus.FRAME_STB}, 8'h01);
    tick(1);                                   // edge 32
    chk("stb_drop", {7'd0, bus.FRAME_STB}, 8'h00);
    chk_out("f1_blank0", 8'hFF, 4'hF);
    tick(1);                                   // edge 33
    chk_out("f1_blank1", 8'hFF, 4'hF);
    tick(1);                                   // edge 34
    chk_out("f1_d0", 8'h99, 4'hE);

    // Test 2: mid-frame change must not tear the frame
    bus.DISPLAY_NUM = 16'hABCD;
    tick(8);                                   // edge 42
    chk_out("f1_d1", 8'hB0, 4'hD);
    tick(8);                                   // edge 50
    chk_out("f1_d2", 8'hA4, 4'hB);
    tick(8);                                   // edge 58
    chk_out("f1_d3", 8'hF9, 4'h7);
    tick(5);                                   // edge 63
    chk("stb_63", {7'd0, bus.FRAME_STB}, 8'h01);
    tick(3);                                   // edge 66
    chk_out("f2_d0_D", 8'hA1, 4'hE);
    tick(8);                                   // edge 74
    chk_out("f2_d1_C", 8'hC6, 4'hD);

    // Test 3: decimal point on digit 1 only, value 0005
    bus.DISPLAY_NUM = 16'h0005;
    bus.DP_MASK     = 4'b0010;
    tick(24);                                  // edge 98
    chk_out("f3_d0_5", 8'h92, 4'hE);
    tick(8);                                   // edge 106
    chk_out("f3_d1_dp", 8'h40, 4'hD);
    tick(8);                                   // edge 114
`ifdef SEG7_LZ_BLANK_EN
    chk_out("f3_d2", 8'hFF, 4'hB);
`else
    chk_out("f3_d2", 8'hC0, 4'hB);
`endif

    // Test 4: drop EN mid-slot, then restart
    bus.EN = 1'b0;
    tick(1);
    chk_out("en_off", 8'hFF, 4'hF);
    chk("en_off_stb", {7'd0, bus.FRAME_STB}, 8'h00);
    tick(2);
    chk_out("en_off_hold", 8'hFF, 4'hF);
    bus.EN = 1'b1;
    tick(1);                                   // restart edge 0
    chk_out("en_re_blank0", 8'hFF, 4'hF);
    tick(1);
    chk_out("en_re_blank1", 8'hFF, 4'hF);
    tick(1);
    chk_out("en_re_d0", 8'h92, 4'hE);

    // Test 5: asynchronous reset between edges during SHOW
    #2;
    RST = 1'b1;
    #1;
    chk_out("async_rst", 8'hFF, 4'hF);
    chk("async_rst_stb", {7'd0, bus.FRAME_STB}, 8'h00);
    #1;
    RST = 1'b0;
    tick(3);                                   // post-reset edge 2
    chk_out("pr_d0", 8'hC0, 4'hE);
    tick(8);                                   // post-reset edge 10
`ifdef SEG7_LZ_BLANK_EN
    chk_out("pr_d1", 8'hFF, 4'hD);
`else
    chk_out("pr_d1", 8'hC0, 4'hD);
`endif

    // Test 6: 0070, leading zeros depend on build macro
    bus.DISPLAY_NUM = 16'h0070;
    bus.DP_MASK     = 4'b0000;
    tick(21);                                  // edge 31
    chk("pr_stb", {7'd0, bus.FRAME_STB}, 8'h01);
    tick(3);                                   // edge 34
    chk_out("lz_d0", 8'hC0, 4'hE);
    tick(8);                                   // edge 42
    chk_out("lz_d1", 8'hF8, 4'hD);
    tick(8);                                   // edge 50
`ifdef SEG7_LZ_BLANK_EN
    chk_out("lz_d2", 8'hFF, 4'hB);
`else
    chk_out("lz_d2", 8'hC0, 4'hB);
`endif
    tick(8);                                   // edge 58
`ifdef SEG7_LZ_BLANK_EN
    chk_out("lz_d3", 8'hFF, 4'h7);
`else
    chk_out("lz_d3", 8'hC0, 4'h7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
